spectrum_wr_ctrl: RTL and testbench



---
 rtl/spectrum_pkg.sv | 26 ++
 rtl/spec_sat_shift.sv | 25 ++
 rtl/spectrum_wr_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_spectrum_wr_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/spectrum_pkg.sv
// Shared constants and types for the spectrum store write/read stages.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spectrum_pkg;

  localparam int N_BINS      = 1024;
  localparam int SPEC_ADDR_W = $clog2(N_BINS);
  localparam int SPEC_DATA_W = 16;
  localparam int SPEC_IN_W   = 24;
  localparam int SPEC_SHIFT  = 8;
  localparam int SPEC_DEC_W  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    SKIP    = 2'd2
  } spec_state_e;

  // One write-port transaction towards the spectrum store.
  typedef struct packed {
    logic                   we;
    logic [SPEC_ADDR_W-1:0] addr;
    logic [SPEC_DATA_W-1:0] data;
  } spec_wr_t;

endpackage

// File: rtl/spec_sat_shift.sv
// Right-shift an unsigned magnitude and saturate it to OUT_W bits.
// Latency: combinational.
// Backpressure: none (pure function of din).
module spec_sat_shift #(
  parameter int IN_W  = 24,
  parameter int OUT_W = 16,
  parameter int SHIFT = 8
) (
  input  logic [IN_W-1:0]  din,
  output logic [OUT_W-1:0] dout
);

  logic [IN_W-1:0] shifted;

  // Shift first, then clamp anything that no longer fits in OUT_W bits.
  always_comb begin
    shifted = din >> SHIFT;
    if (|(shifted >> OUT_W)) begin
      dout = '1;
    end else begin
      dout = shifted[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/spectrum_wr_ctrl.sv
// Frames the FFT magnitude stream on SOP/EOP and writes scaled bins into the spectrum store.
// Latency: wea/addra/dina and frame_done/err_* registered, 1 cycle after the beat.
// Backpressure: none; every valid beat is consumed. SPEC_DECIM_EN adds frame decimation via dec_ratio.
module spectrum_wr_ctrl
  import spectrum_pkg::*;
#(
  parameter int IN_W  = SPEC_IN_W,
  parameter int SHIFT = SPEC_SHIFT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   freeze,
  input  logic                   s_valid,
  input  logic                   s_sop,
  input  logic                   s_eop,
  input  logic [IN_W-1:0]        s_data,
`ifdef SPEC_DECIM_EN
  input  logic [SPEC_DEC_W-1:0]  dec_ratio,
`endif
  output logic                   wea,
  output logic [SPEC_ADDR_W-1:0] addra,
  output logic [SPEC_DATA_W-1:0] dina,
  output logic                   frame_done,
  output logic                   busy,
  output logic                   err_short,
  output logic                   err_long
);

  // One extra bit so the counter can represent "one past the last bin".
  localparam int                CNT_W    = SPEC_ADDR_W + 1;
  localparam logic [CNT_W-1:0]  LAST_BIN = CNT_W'(N_BINS - 1);
  localparam logic [CNT_W-1:0]  FULL_BIN = CNT_W'(N_BINS);

  spec_state_e            state_q, state_d;
  logic [CNT_W-1:0]       bin_q, bin_d;
  spec_wr_t               wr_q, wr_d;
  logic                   done_q, done_d;
  logic                   short_q, short_d;
  logic                   long_q, long_d;
  logic                   busy_q, busy_d;
  logic [SPEC_DATA_W-1:0] sat_dat;
  logic                   sop_beat;
  logic                   selected;
  logic                   accept;

  spec_sat_shift #(
    .IN_W  (IN_W),
    .OUT_W (SPEC_DATA_W),
    .SHIFT (SHIFT)
  ) u_sat (
    .din  (s_data),
    .dout (sat_dat)
  );

  assign sop_beat = s_valid & s_sop;

`ifdef SPEC_DECIM_EN
  logic [SPEC_DEC_W-1:0] dec_cnt_q, dec_cnt_d;
  logic [SPEC_DEC_W-1:0] dec_lim_q, dec_lim_d;
  logic [SPEC_DEC_W-1:0] dec_lim_eff;

  // Decimation counter: steps on every SOP; the ratio is latched at the start of each period.
  always_comb begin
    dec_lim_eff = (dec_cnt_q == '0) ? dec_ratio : dec_lim_q;
    dec_cnt_d   = dec_cnt_q;
    dec_lim_d   = dec_lim_q;
    if (sop_beat) begin
      dec_lim_d = dec_lim_eff;
      dec_cnt_d = (dec_cnt_q >= dec_lim_eff) ? '0 : dec_cnt_q + 1'b1;
    end
  end

  assign selected = (dec_cnt_q == '0);
`else
  assign selected = 1'b1;
`endif

  // Freeze only matters at the SOP that would start a frame.
  assign accept = sop_beat & ~freeze & selected;

  // Next-state, bin counter and write-port computation.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    wr_d    = wr_q;
    wr_d.we = 1'b0;
    done_d  = 1'b0;
    short_d = 1'b0;
    long_d  = 1'b0;

    if (s_valid) begin
      if (s_sop) begin
        // A SOP inside a frame truncates it; the new frame faces the same accept rule.
        if (state_q == CAPTURE) begin
          short_d = 1'b1;
        end
        if (accept) begin
          wr_d.we   = 1'b1;
          wr_d.addr = '0;
          wr_d.data = sat_dat;
          if (s_eop) begin
            done_d  = (N_BINS == 1);
            short_d = (N_BINS > 1);
            state_d = IDLE;
            bin_d   = '0;
          end else begin
            state_d = CAPTURE;
            bin_d   = CNT_W'(1);
          end
        end else begin
          state_d = s_eop ? IDLE : SKIP;
          bin_d   = '0;
        end
      end else begin
        case (state_q)
          CAPTURE: begin
            if (bin_q == FULL_BIN) begin
              // First beat past the store: flag once, drop the rest of the frame.
              long_d  = 1'b1;
              state_d = s_eop ? IDLE : SKIP;
              bin_d   = '0;
            end else begin
              wr_d.we   = 1'b1;
              wr_d.addr = bin_q[SPEC_ADDR_W-1:0];
              wr_d.data = sat_dat;
              if (s_eop) begin
                done_d  = (bin_q == LAST_BIN);
                short_d = (bin_q != LAST_BIN);
                state_d = IDLE;
                bin_d   = '0;
              end else begin
                bin_d = bin_q + 1'b1;
              end
            end
          end
          SKIP: begin
            if (s_eop) begin
              state_d = IDLE;
            end
          end
          default: begin
            // IDLE: beats without SOP belong to no frame.
          end
        endcase
      end
    end

    busy_d = (state_d == CAPTURE);
  end

  // FSM, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      wr_q      <= '0;
      done_q    <= 1'b0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      busy_q    <= 1'b0;
`ifdef SPEC_DECIM_EN
      dec_cnt_q <= '0;
      dec_lim_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      wr_q      <= wr_d;
      done_q    <= done_d;
      short_q   <= short_d;
      long_q    <= long_d;
      busy_q    <= busy_d;
`ifdef SPEC_DECIM_EN
      dec_cnt_q <= dec_cnt_d;
      dec_lim_q <= dec_lim_d;
`endif
    end
  end

  assign wea        = wr_q.we;
  assign addra      = wr_q.addr;
  assign dina       = wr_q.data;
  assign frame_done = done_q;
  assign busy       = busy_q;
  assign err_short  = short_q;
  assign err_long   = long_q;

endmodule

// File: tb/tb_spectrum_wr_ctrl.sv
// Scoreboard bench for spectrum_wr_ctrl: expected store writes are queued as beats are driven.
// Latency: writes expected 1 cycle after each accepted beat, sampled on the falling edge.
// Backpressure: none; the bench drives beats freely with optional idle gaps.
module tb_spectrum_wr_ctrl;
  import spectrum_pkg::*;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic        freeze  = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_sop   = 1'b0;
  logic        s_eop   = 1'b0;
  logic [23:0] s_data  = '0;
`ifdef SPEC_DECIM_EN
  logic [SPEC_DEC_W-1:0] dec_ratio = '0;
`endif
  logic        wea;
  logic [9:0]  addra;
  logic [15:0] dina;
  logic        frame_done;
  logic        busy;
  logic        err_short;
  logic        err_long;

  int tests_run    = 0;
  int tests_failed = 0;
  int n_wr = 0, n_done = 0, n_short = 0, n_long = 0;
  int b_wr = 0, b_done = 0, b_short = 0, b_long = 0;
  bit pend_short = 1'b0;

  // {addr, data, busy, frame_done, err_short, err_long}
  logic [29:0] exp_q[$];

  always #5 clk = ~clk;

  spectrum_wr_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .freeze     (freeze),
    .s_valid    (s_valid),
    .s_sop      (s_sop),
    .s_eop      (s_eop),
    .s_data     (s_data),
`ifdef SPEC_DECIM_EN
    .dec_ratio  (dec_ratio),
`endif
    .wea        (wea),
    .addra      (addra),
    .dina       (dina),
    .frame_done (frame_done),
    .busy       (busy),
    .err_short  (err_short),
    .err_long   (err_long)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] sat16(input logic [23:0] d);
    logic [23:0] t;
    t = d >> 8;
    return (t > 24'h00FFFF) ? 16'hFFFF : t[15:0];
  endfunction

  // Monitor: every write is popped against the scoreboard; pulses are tallied.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_done) n_done++;
      if (err_short)  n_short++;
      if (err_long)   n_long++;
      if (wea) begin
        n_wr++;
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 32'(exp_q.size()), 32'd1);
        end else begin
          chk("write", {2'b0, addra, dina, busy, frame_done, err_short, err_long},
              {2'b0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      s_valid = 1'b0;
      s_sop   = 1'($urandom_range(0, 1));
      s_eop   = 1'($urandom_range(0, 1));
      s_data  = 24'($urandom);
      @(posedge clk);
    end
    #1;
  endtask

  task automatic beat(input logic sop, input logic eop, input logic [23:0] d);
    s_valid = 1'b1;
    s_sop   = sop;
    s_eop   = eop;
    s_data  = d;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_sop   = 1'b0;
    s_eop   = 1'b0;
  endtask

  // mode 0: data=k<<8, mode 1: random, mode 2: saturation pair.
  task automatic send_frame(input int nb, input bit written, input int mode,
                            input bit gaps, input int frz_k, input bit with_eop);
    for (int k = 0; k < nb; k++) begin
      logic [23:0] d;
      logic [15:0] ed;
      logic        last;
      case (mode)
        0:       d = 24'(k) << 8;
        1:       d = 24'($urandom);
        default: d = (k == 0) ? 24'hFFFFFF : 24'h00FF00;
      endcase
      if (k == frz_k) freeze = 1'b1;
      last = with_eop && (k == nb - 1);
      if (written && k < N_BINS) begin
        if (mode == 0)      ed = 16'(k);
        else if (mode == 1) ed = sat16(d);
        else                ed = (k == 0) ? 16'hFFFF : 16'h00FF;
        exp_q.push_back({10'(k), ed, ~last, last && (nb == N_BINS),
                         (last && (nb < N_BINS)) || (k == 0 && pend_short), 1'b0});
      end
      pend_short = 1'b0;
      beat(k == 0, last, d);
      if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
  endtask

  task automatic mark();
    b_wr = n_wr; b_done = n_done; b_short = n_short; b_long = n_long;
  endtask

  task automatic settle(input string tag, input int e_wr, input int e_done,
                        input int e_short, input int e_long);
    idle(4);
    chk({tag, "_writes"}, 32'(n_wr - b_wr), 32'(e_wr));
    chk({tag, "_done"},   32'(n_done - b_done), 32'(e_done));
    chk({tag, "_short"},  32'(n_short - b_short), 32'(e_short));
    chk({tag, "_long"},   32'(n_long - b_long), 32'(e_long));
    chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {25'b0, wea, frame_done, busy, err_short, err_long, 2'b0}, 32'd0);
    chk("reset_bus", {6'b0, addra, dina}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // Clean 1024-bin frame, dina = k.
    mark(); send_frame(1024, 1, 0, 0, -1, 1); settle("clean", 1024, 1, 0, 0);

    // Saturation pair in a 2-bin (short) frame.
    mark(); send_frame(2, 1, 2, 0, -1, 1); settle("sat", 2, 0, 1, 0);

    // Short frame with gaps, then a single-beat frame restarting at bin 0.
    mark(); send_frame(500, 1, 1, 1, -1, 1); settle("short", 500, 0, 1, 0);
    mark(); send_frame(1, 1, 1, 0, -1, 1); settle("single", 1, 0, 1, 0);

    // Long frame: 1030 beats, only 1024 written, err_long once.
    mark(); send_frame(1030, 1, 1, 0, -1, 1); settle("long", 1024, 0, 0, 1);

    // Freeze high at SOP drops the frame; freeze rising mid-frame does not.
    freeze = 1'b1;
    mark(); send_frame(1024, 0, 1, 0, -1, 1); settle("freeze_sop", 0, 0, 0, 0);
    freeze = 1'b0;
    mark(); send_frame(1024, 1, 1, 1, 100, 1); settle("freeze_mid", 1024, 1, 0, 0);
    freeze = 1'b0;

    // SOP in the middle of a frame: err_short on the restart write at bin 0.
    mark();
    send_frame(300, 1, 1, 0, -1, 0);
    pend_short = 1'b1;
    send_frame(1024, 1, 0, 0, -1, 1);
    settle("restart", 1324, 1, 1, 0);

    // Reset mid-frame abandons the frame; next SOP starts at bin 0.
    mark();
    send_frame(10, 1, 1, 0, -1, 0);
    idle(1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_outputs", {26'b0, wea, frame_done, busy, err_short, err_long, 1'b0}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);
    send_frame(5, 1, 1, 0, -1, 1);
    settle("rst_mid", 15, 0, 1, 0);

`ifdef SPEC_DECIM_EN
    // dec_ratio=2: of six frames only 0 and 3 are written.
    dec_ratio = 4'd2;
    mark();
    for (int f = 0; f < 6; f++) send_frame(1024, (f % 3) == 0, 1, f == 1, -1, 1);
    settle("decim", 2048, 2, 0, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
